fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
// -----------
// Instruction fetch stage. It owns the program counter and the IF/ID
// pipeline register. It chooses the next fetch address from:
//   - the exception and interrupt vectors,
//   - EX-stage redirects,
//   - ID-stage jumps,
//   - sequential PC+4.
// On a trap it captures the return address in EPC.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   PC                  : current fetch address (instruction memory address)
//   Instruction         : instruction word returned combinationally for PC
//   Stall               : load-use stall, holds PC and IF/ID
//   Flush               : squash IF/ID without touching PC
//   Jump / JumpTarget   : ID-stage j/jal and its destination
//   Redirect / RedirectTarget : EX-stage taken branch or jr/jalr
//   IRQ                 : level interrupt request, honoured in user mode only
//   Exception           : undefined-instruction trap from ID
//   IFID_Instruction, IFID_PCPlus4, IFID_Valid : IF/ID pipeline register
//   EPC                 : return address captured on trap entry
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h80000000,
  parameter logic [31:0] IRQ_VECTOR = 32'h80000004,
  parameter logic [31:0] EXC_VECTOR = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        IRQ,
  input  logic        Exception,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] EPC
);

  logic [31:0] pcPlus4;
  logic [31:0] nextPcRaw;
  logic [31:0] nextPc;
  logic        irqTaken;
  logic        jumpTaken;
  logic        trapTaken;
  logic        bubble;

  // Sequential increment keeps the kernel bit (bit 31) fixed.
  // The low 31 bits wrap modulo 2^31.
  // Interrupts are only accepted in user mode; in kernel mode the request
  // simply stays pending on the level input.
  // A jump resolved in ID is deferred while the pipe is stalled.
  always_comb begin
    pcPlus4   = {PC[31], PC[30:0] + 31'd4};
    irqTaken  = IRQ & ~PC[31];
    jumpTaken = Jump & ~Stall;
    trapTaken = Exception | irqTaken;
    bubble    = Flush | trapTaken | Redirect | jumpTaken;
  end

  // Next-PC selection. Traps and redirects win over a stall, because the
  // stalled instruction is being thrown away anyway.
  // Every loaded address is word-aligned by clearing the two low bits.
  always_comb begin
    nextPcRaw = pcPlus4;
    if (Exception) begin
      nextPcRaw = EXC_VECTOR;
    end else if (irqTaken) begin
      nextPcRaw = IRQ_VECTOR;
    end else if (Redirect) begin
      nextPcRaw = RedirectTarget;
    end else if (jumpTaken) begin
      nextPcRaw = JumpTarget;
    end else if (Stall) begin
      nextPcRaw = PC;
    end
    nextPc = {nextPcRaw[31:2], 2'b00};
  end

  // PC and EPC update.
  // EPC records the fetch address being discarded, so that a return
  // re-fetches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC  <= RESET_PC;
      EPC <= 32'h0;
    end else begin
      PC <= nextPc;
      if (trapTaken) begin
        EPC <= PC;
      end
    end
  end

  // IF/ID register: a bubble takes priority over a stall, a stall holds,
  // and otherwise the freshly fetched word is captured. No delay slot
  // exists, so any control transfer squashes the fetch of this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      IFID_Instruction <= 32'h0;
      IFID_PCPlus4     <= 32'h0;
      IFID_Valid       <= 1'b0;
    end else if (bubble) begin
      IFID_Instruction <= 32'h0;
      IFID_PCPlus4     <= 32'h0;
      IFID_Valid       <= 1'b0;
    end else if (!Stall) begin
      IFID_Instruction <= Instruction;
      IFID_PCPlus4     <= pcPlus4;
      IFID_Valid       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// --------------
// Self-checking bench for fetch_stage. A directed vector table walks the
// boot, stall, redirect, interrupt, exception, jump and wrap corner cases.
// A randomised run is then compared against a behavioural model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Flush;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        IRQ;
  logic        Exception;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] EPC;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .PC(PC),
    .Instruction(Instruction),
    .Stall(Stall),
    .Flush(Flush),
    .Jump(Jump),
    .JumpTarget(JumpTarget),
    .Redirect(Redirect),
    .RedirectTarget(RedirectTarget),
    .IRQ(IRQ),
    .Exception(Exception),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid),
    .EPC(EPC)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed hash of the word address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  assign Instruction = imem(PC);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        jump;
    logic [31:0] jt;
    logic        redirect;
    logic [31:0] rt;
    logic        irq;
    logic        exc;
    logic [31:0] ePc;
    logic [31:0] eP4;
    logic        eV;
    logic [31:0] eEpc;
  } vec_t;

  vec_t vecs[$];

  // Appends one row to the directed vector table.
  // The stimulus fields come first, then the expected state after the edge.
  task automatic addRow(input logic rst, input logic st, input logic fl,
                        input logic jp, input logic [31:0] jt,
                        input logic rd, input logic [31:0] rt,
                        input logic irq, input logic ex,
                        input logic [31:0] pc, input logic [31:0] p4,
                        input logic v, input logic [31:0] epc);
    vec_t r;
    r.rst = rst; r.stall = st; r.flush = fl; r.jump = jp; r.jt = jt;
    r.redirect = rd; r.rt = rt; r.irq = irq; r.exc = ex;
    r.ePc = pc; r.eP4 = p4; r.eV = v; r.eEpc = epc;
    vecs.push_back(r);
  endtask

  // Compares one observed value against its expected value.
  // A mismatch prints a FAIL line and bumps the error count.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, clocks once, then waits 1 time unit.
  // The outputs are sampled after that delay, clear of the active edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic fl,
                               input logic jp, input logic [31:0] jt,
                               input logic rd, input logic [31:0] rt,
                               input logic irq, input logic ex);
    reset = rst; Stall = st; Flush = fl; Jump = jp; JumpTarget = jt;
    Redirect = rd; RedirectTarget = rt; IRQ = irq; Exception = ex;
    @(posedge clk);
    #1;
  endtask

  // Sequential increment of the behavioural model.
  // The kernel bit is kept and the low 31 bits wrap.
  function automatic logic [31:0] seqNext(input logic [31:0] a);
    return (a & 32'h80000000) | ((a + 32'd4) & 32'h7FFFFFFF);
  endfunction

  // Recovers the fetch address from a PC+4 value.
  // This is the inverse of seqNext.
  function automatic logic [31:0] seqPrev(input logic [31:0] a);
    return (a & 32'h80000000) | ((a - 32'd4) & 32'h7FFFFFFF);
  endfunction

  // Behavioural model state.
  logic [31:0] mPc, mIr, mP4, mEpc;
  logic        mV;

  // Advances the model by one clock edge for the given inputs.
  task automatic modelStep(input logic rst, input logic st, input logic fl,
                           input logic jp, input logic [31:0] jt,
                           input logic rd, input logic [31:0] rt,
                           input logic irq, input logic ex);
    logic        userIrq;
    logic        squash;
    logic [31:0] target;
    if (rst) begin
      mPc = 32'h80000000; mIr = 0; mP4 = 0; mV = 0; mEpc = 0;
      return;
    end
    userIrq = irq && (mPc < 32'h80000000);
    squash  = fl || ex || userIrq || rd || (jp && !st);
    if (ex)               target = 32'h80000008;
    else if (userIrq)     target = 32'h80000004;
    else if (rd)          target = rt;
    else if (jp && !st)   target = jt;
    else if (st)          target = mPc;
    else                  target = seqNext(mPc);
    if (squash) begin
      mIr = 0; mP4 = 0; mV = 0;
    end else if (!st) begin
      mIr = imem(mPc); mP4 = seqNext(mPc); mV = 1;
    end
    if (ex || userIrq) mEpc = mPc;
    mPc = target - (target % 4);
  endtask

  initial begin
    logic [31:0] expIr;
    reset = 1'b1; Stall = 0; Flush = 0; Jump = 0; JumpTarget = 0;
    Redirect = 0; RedirectTarget = 0; IRQ = 0; Exception = 0;

    // rst st fl jp jt           rd rt           irq ex -> pc          p4          v epc
    addRow(1,0,0,0,0,            0,0,            0,0, 32'h80000000,32'h0,       0,32'h0);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h80000004,32'h80000004,1,32'h0);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h80000008,32'h80000008,1,32'h0);
    addRow(0,0,0,0,0,            1,32'h0000000C, 0,0, 32'h0000000C,32'h0,       0,32'h0);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h00000010,32'h00000010,1,32'h0);
    addRow(0,1,0,0,0,            0,0,            0,0, 32'h00000010,32'h00000010,1,32'h0);
    addRow(0,1,0,0,0,            0,0,            0,0, 32'h00000010,32'h00000010,1,32'h0);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h00000014,32'h00000014,1,32'h0);
    addRow(0,0,0,0,0,            1,32'h0000001C, 0,0, 32'h0000001C,32'h0,       0,32'h0);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h00000020,32'h00000020,1,32'h0);
    addRow(0,1,0,0,0,            1,32'h00000040, 0,0, 32'h00000040,32'h0,       0,32'h0);
    addRow(0,0,0,0,0,            1,32'h00000008, 0,0, 32'h00000008,32'h0,       0,32'h0);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h0000000C,32'h0000000C,1,32'h0);
    addRow(0,0,0,0,0,            0,0,            1,0, 32'h80000004,32'h0,       0,32'h0000000C);
    addRow(0,0,0,0,0,            1,32'h8000000C, 0,0, 32'h8000000C,32'h0,       0,32'h0000000C);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h80000010,32'h80000010,1,32'h0000000C);
    addRow(0,0,0,0,0,            0,0,            1,0, 32'h80000014,32'h80000014,1,32'h0000000C);
    addRow(0,0,0,0,0,            1,32'h0000002C, 0,0, 32'h0000002C,32'h0,       0,32'h0000000C);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h00000030,32'h00000030,1,32'h0000000C);
    addRow(0,0,0,0,0,            1,32'h00000040, 0,1, 32'h80000008,32'h0,       0,32'h00000030);
    addRow(0,0,0,1,32'h00000100, 0,0,            0,0, 32'h00000100,32'h0,       0,32'h00000030);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h00000104,32'h00000104,1,32'h00000030);
    addRow(0,1,0,1,32'h00000200, 0,0,            0,0, 32'h00000104,32'h00000104,1,32'h00000030);
    addRow(0,0,1,0,0,            0,0,            0,0, 32'h00000108,32'h0,       0,32'h00000030);
    addRow(0,0,0,0,0,            1,32'h00000203, 0,0, 32'h00000200,32'h0,       0,32'h00000030);
    addRow(0,0,0,0,0,            1,32'h7FFFFFF8, 0,0, 32'h7FFFFFF8,32'h0,       0,32'h00000030);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h7FFFFFFC,32'h7FFFFFFC,1,32'h00000030);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h00000000,32'h00000000,1,32'h00000030);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h00000004,32'h00000004,1,32'h00000030);
    addRow(0,0,0,0,0,            0,0,            1,0, 32'h80000004,32'h0,       0,32'h00000004);
    addRow(1,0,0,0,0,            0,0,            1,0, 32'h80000000,32'h0,       0,32'h0);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h80000004,32'h80000004,1,32'h0);
    addRow(0,1,0,0,0,            0,0,            0,0, 32'h80000004,32'h80000004,1,32'h0);
    addRow(1,1,0,0,0,            1,32'h00000040, 0,0, 32'h80000000,32'h0,       0,32'h0);
    addRow(0,0,0,0,0,            0,0,            0,0, 32'h80000004,32'h80000004,1,32'h0);

    // Directed table: hand-derived expectations after each clock edge.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].jump,
                    vecs[i].jt, vecs[i].redirect, vecs[i].rt, vecs[i].irq,
                    vecs[i].exc);
      expIr = vecs[i].eV ? imem(seqPrev(vecs[i].eP4)) : 32'h0;
      checkOutput($sformatf("vec%0d.PC", i), PC, vecs[i].ePc);
      checkOutput($sformatf("vec%0d.IFID_PCPlus4", i), IFID_PCPlus4, vecs[i].eP4);
      checkOutput($sformatf("vec%0d.IFID_Valid", i), {31'b0, IFID_Valid}, {31'b0, vecs[i].eV});
      checkOutput($sformatf("vec%0d.IFID_Instruction", i), IFID_Instruction, expIr);
      checkOutput($sformatf("vec%0d.EPC", i), EPC, vecs[i].eEpc);
    end

    // Randomised run against the behavioural model.
    // It starts from a clean reset.
    modelStep(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      logic        r, s, f, j, rd, q, e;
      logic [31:0] jt, rt;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 25);
      f  = ($urandom_range(0, 99) < 10);
      j  = ($urandom_range(0, 99) < 15);
      rd = ($urandom_range(0, 99) < 10);
      q  = ($urandom_range(0, 99) < 15);
      e  = ($urandom_range(0, 99) < 5);
      jt = $urandom;
      rt = $urandom;
      modelStep(r, s, f, j, jt, rd, rt, q, e);
      applyStimulus(r, s, f, j, jt, rd, rt, q, e);
      checkOutput("rnd.PC", PC, mPc);
      checkOutput("rnd.IFID_Instruction", IFID_Instruction, mIr);
      checkOutput("rnd.IFID_PCPlus4", IFID_PCPlus4, mP4);
      checkOutput("rnd.IFID_Valid", {31'b0, IFID_Valid}, {31'b0, mV});
      checkOutput("rnd.EPC", EPC, mEpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
